lsu_ctrl: RTL and testbench
===========================

# lsu_ctrl

Load/store unit sitting between the decode stage and the data-memory bus. It consumes the memory-control outputs of the control unit (`MemWrite`, `DataWidth`, signedness) together with the ALU-computed address. It then runs a valid/ready transaction on the data bus, with byte-lane steering and byte enables. Completed loads are returned sign- or zero-extended to 32 bits, and the core stalls until the access finishes.

## Interface
Parameters:
- `ADDR_W`, 32: byte-address width.

Ports (clock and reset first; one clock domain; `rst_n` is asynchronous and active-low):
- `clk`  in  1  system clock, all state on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `Req`  in  1  memory instruction present; `MemWrite`, `DataWidth`, `Unsigned`, `Addr`, `WData` held stable while `Req` && !`Done`.
- `MemWrite`  in  1  1 = store, 0 = load.
- `DataWidth`  in  2  00 word, 01 half, 10 byte; 11 treated as word.
- `Unsigned`  in  1  load zero-extends (funct3[2]); ignored for stores.
- `Addr`  in  ADDR_W  byte address.
- `WData`  in  32  store data, right-aligned.
- `RData`  out  32  extended load result, valid while `Done`=1.
- `Done`  out  1  one-cycle completion pulse.
- `Stall`  out  1  = `Req` && !`Done`; freezes the pipeline.
- `MisalignErr`  out  1  one-cycle pulse, misaligned access rejected (only when `LSU_MISALIGN_EN` is undefined).
- `BusValid`  out  1  bus request valid.
- `BusAddr`  out  ADDR_W  word-aligned address (bits [1:0] = 00).
- `BusWe`  out  1  bus write.
- `BusBe`  out  4  byte enables.
- `BusWData`  out  32  lane-steered write data.
- `BusReady`  in  1  bus accepts/completes the beat.
- `BusRData`  in  32  read word, valid when `BusValid` && `BusReady`.

## Operation
- Access size: N = 4/2/1 bytes. Offset: off = `Addr[1:0]`. Mask = 4'b1111/4'b0011/4'b0001.
- An access is split when off + N > 4.
- States: IDLE, BEAT0, BEAT1, DONE.
- IDLE: `Req`=1 and not split → BEAT0. `Req`=1 and split → BEAT0 if the macro is defined, else pulse `MisalignErr` and stay in IDLE. `Req` stays high and `Stall` stays high; the core must flush or trap.
- BEAT0: `BusAddr` = {Addr[ADDR_W-1:2], 2'b00}, `BusBe` = (Mask << off)[3:0], `BusWData` = WData << 8·off. On handshake, go to BEAT1 if split, else DONE.
- BEAT1: `BusAddr` = previous word address + 4 (wraps modulo 2^ADDR_W), `BusBe` = Mask >> (4−off), `BusWData` = WData >> 8·(4−off). On handshake → DONE.
- Load assembly: bytes are captured per beat into a 32-bit shift register. Beat0 supplies bytes off..3 of the word; beat1 supplies bytes 0..(off+N−5).
- Extension: bit 7 / bit 15 of the assembled value is replicated when `Unsigned`=0, else zero-filled. Word loads pass through unchanged.
- DONE: `Done`=1 for one cycle. `RData` is driven from a register for loads and is 0 for stores. Next state is IDLE.
- Once BEAT0 is entered, the transaction always completes. Dropping `Req` mid-transaction does not abort it; `Done` still pulses.

## Timing
- Reset values: state IDLE; `BusValid`, `BusWe`, `Done`, `MisalignErr` = 0; `BusAddr`, `BusBe`, `BusWData`, `RData` = 0.
- Asserting `rst_n` low mid-transaction deasserts `BusValid` immediately (asynchronously) and discards partial data.
- All bus outputs are registered.
- `BusValid`, `BusAddr`, `BusBe`, `BusWe`, `BusWData` are held stable until the `BusReady` handshake.
- A handshake is `BusValid` && `BusReady` at a rising edge.
- Latency with `BusReady` tied high: aligned, `Req` sampled at edge 0 → `BusValid` in cycle 1 → `Done` in cycle 2. Split, `Done` in cycle 3. Each cycle of `BusReady` low adds one cycle.
- Back-to-back: a new `Req` is sampled in the cycle after DONE, giving a minimum of 3 cycles per aligned access.
- `MisalignErr` pulses in the cycle following the sampling edge.

## Configuration
- `LSU_MISALIGN_EN` defined: split accesses are executed as two beats (BEAT0, BEAT1). `MisalignErr` is tied 0.
- `LSU_MISALIGN_EN` undefined: BEAT1 logic is removed. Split accesses never reach the bus and raise `MisalignErr`.

## Test plan
- Aligned word load, Addr=0x100, BusRData=0xDEADBEEF, `BusReady` high → one beat with BusAddr=0x100, BusBe=1111; `Done` in cycle 2 with RData=0xDEADBEEF.
- Signed byte load, Addr=0x103, BusRData=0x80xxxxxx → BusBe=1000, RData=0xFFFFFF80. Repeat with Unsigned=1 → RData=0x00000080.
- Half store, Addr=0x202, WData=0x1234ABCD, `BusReady` low for 3 cycles → BusBe=1100 and BusWData=0xABCD0000, both held across all 4 cycles; `Done` pulses once.
- Misaligned word load, Addr=0x301, macro defined → beat0 BusAddr=0x300, Be=1110; beat1 BusAddr=0x304, Be=0001. With words 0x332211xx and 0xxxxxxx44, RData=0x44332211. Macro undefined → no BusValid; MisalignErr pulses once.
- Wrap-around: misaligned half at Addr=0xFFFFFFFF → beat1 BusAddr=0x00000000.
- `rst_n` low during BEAT1 with `BusReady` low → `BusValid`=0 immediately, no `Done`; after release, a new Req at 0x100 completes normally.

Source files
------------

// File: rtl/lsu_ctrl_if.sv
// rtl/lsu_ctrl_if.sv - data-memory bus bundle between lsu_ctrl and the memory
//
// Signals:
//   BusValid  request valid (master)
//   BusAddr   word-aligned byte address (master)
//   BusWe     write strobe (master)
//   BusBe     byte enables (master)
//   BusWData  lane-steered write data (master)
//   BusReady  beat accepted/completed (slave)
//   BusRData  read word, valid with BusValid && BusReady (slave)
interface lsu_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              BusValid;
  logic [ADDR_W-1:0] BusAddr;
  logic              BusWe;
  logic [3:0]        BusBe;
  logic [31:0]       BusWData;
  logic              BusReady;
  logic [31:0]       BusRData;

  modport master (
    output BusValid, BusAddr, BusWe, BusBe, BusWData,
    input  BusReady, BusRData
  );

  modport slave (
    input  BusValid, BusAddr, BusWe, BusBe, BusWData,
    output BusReady, BusRData
  );
endinterface

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store unit sequencing core memory ops onto the data bus
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   Req             memory instruction present
//   MemWrite        1 = store, 0 = load
//   DataWidth       00 word, 01 half, 10 byte, 11 word
//   Unsigned        zero-extend loads
//   Addr, WData     byte address, right-aligned store data
//   RData           extended load result, valid with Done
//   Done            one-cycle completion pulse
//   Stall           Req && !Done
//   MisalignErr     one-cycle pulse when a split access is rejected
//   bus             lsu_ctrl_if master modport (valid/ready data bus)
//
// Macro LSU_MISALIGN_EN: when defined, accesses crossing a word boundary run
// as two bus beats; when undefined they are rejected with MisalignErr.
module lsu_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Req,
  input  logic              MemWrite,
  input  logic [1:0]        DataWidth,
  input  logic              Unsigned,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [31:0]       WData,
  output logic [31:0]       RData,
  output logic              Done,
  output logic              Stall,
  output logic              MisalignErr,
  lsu_ctrl_if.master        bus
);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} state_t;

  state_t            r_state;
  logic              r_valid;
  logic              r_we;
  logic              r_done;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_be;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  // Request attributes latched at acceptance: Req may drop mid-transaction.
  logic [1:0]        r_off;
  logic [1:0]        r_width;
  logic              r_uns;

  logic [1:0]        w_off;
  logic [3:0]        w_mask;
  logic [2:0]        w_n;
  logic              w_split;
  logic [3:0]        w_be0;
  logic [31:0]       w_wd0;
  logic [31:0]       w_rd0;
  logic [31:0]       w_asm;
  logic [31:0]       w_ext;
  logic              w_accept;

  assign w_off = Addr[1:0];

  always_comb begin
    w_mask = 4'b1111;
    w_n    = 3'd4;
    case (DataWidth)
      2'b01: begin
        w_mask = 4'b0011;
        w_n    = 3'd2;
      end
      2'b10: begin
        w_mask = 4'b0001;
        w_n    = 3'd1;
      end
      default: ;
    endcase
  end

  assign w_split = ({1'b0, w_off} + w_n) > 3'd4;

  // First beat: lanes off..3. Bits shifted past lane 3 belong to the second beat.
  assign w_be0 = w_mask << w_off;
  assign w_wd0 = WData << {w_off, 3'b000};
  assign w_rd0 = bus.BusRData >> {r_off, 3'b000};

`ifdef LSU_MISALIGN_EN
  logic        r_split;
  logic [3:0]  r_be1;
  logic [31:0] r_wd1;
  logic [31:0] r_raw;
  logic [3:0]  w_be1;
  logic [31:0] w_wd1;
  logic [31:0] w_rd1;

  assign w_be1 = w_mask >> (3'd4 - {1'b0, w_off});
  assign w_wd1 = WData >> (6'd32 - {1'b0, w_off, 3'b000});
  // Second-beat lanes 0.. land above the 4-off bytes gathered by beat 0.
  assign w_rd1 = r_raw | (bus.BusRData << (6'd32 - {1'b0, r_off, 3'b000}));

  assign w_accept    = (r_state == IDLE) && Req;
  assign w_asm       = (r_state == BEAT1) ? w_rd1 : w_rd0;
  assign MisalignErr = 1'b0;
`else
  logic r_misalign;
  // Set once a split request has been flagged so a still-asserted Req
  // does not re-raise MisalignErr every cycle.
  logic r_err_hold;
  logic w_err;

  assign w_accept    = (r_state == IDLE) && Req && !w_split && !r_err_hold;
  assign w_err       = (r_state == IDLE) && Req && w_split && !r_err_hold;
  assign w_asm       = w_rd0;
  assign MisalignErr = r_misalign;
`endif

  always_comb begin
    w_ext = w_asm;
    case (r_width)
      2'b01: w_ext = r_uns ? {16'h0000, w_asm[15:0]} : {{16{w_asm[15]}}, w_asm[15:0]};
      2'b10: w_ext = r_uns ? {24'h000000, w_asm[7:0]} : {{24{w_asm[7]}}, w_asm[7:0]};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_valid    <= 1'b0;
      r_we       <= 1'b0;
      r_done     <= 1'b0;
      r_addr     <= '0;
      r_be       <= 4'b0000;
      r_wdata    <= 32'h0;
      r_rdata    <= 32'h0;
      r_off      <= 2'b00;
      r_width    <= 2'b00;
      r_uns      <= 1'b0;
`ifdef LSU_MISALIGN_EN
      r_split    <= 1'b0;
      r_be1      <= 4'b0000;
      r_wd1      <= 32'h0;
      r_raw      <= 32'h0;
`else
      r_misalign <= 1'b0;
      r_err_hold <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
`ifndef LSU_MISALIGN_EN
      r_misalign <= w_err;
      if (!Req)
        r_err_hold <= 1'b0;
      else if (w_err)
        r_err_hold <= 1'b1;
`endif
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state <= BEAT0;
            r_valid <= 1'b1;
            r_addr  <= {Addr[ADDR_W-1:2], 2'b00};
            r_we    <= MemWrite;
            r_be    <= w_be0;
            r_wdata <= w_wd0;
            r_off   <= w_off;
            r_width <= DataWidth;
            r_uns   <= Unsigned;
`ifdef LSU_MISALIGN_EN
            r_split <= w_split;
            r_be1   <= w_be1;
            r_wd1   <= w_wd1;
`endif
          end
        end
        BEAT0: begin
          if (bus.BusReady) begin
`ifdef LSU_MISALIGN_EN
            if (r_split) begin
              r_state <= BEAT1;
              r_addr  <= r_addr + ADDR_W'(4);
              r_be    <= r_be1;
              r_wdata <= r_wd1;
              r_raw   <= w_rd0;
            end else
`endif
            begin
              r_state <= DONE;
              r_valid <= 1'b0;
              r_done  <= 1'b1;
              r_rdata <= r_we ? 32'h0 : w_ext;
            end
          end
        end
`ifdef LSU_MISALIGN_EN
        BEAT1: begin
          if (bus.BusReady) begin
            r_state <= DONE;
            r_valid <= 1'b0;
            r_done  <= 1'b1;
            r_rdata <= r_we ? 32'h0 : w_ext;
          end
        end
`endif
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.BusValid = r_valid;
  assign bus.BusAddr  = r_addr;
  assign bus.BusWe    = r_we;
  assign bus.BusBe    = r_be;
  assign bus.BusWData = r_wdata;
  assign RData        = r_rdata;
  assign Done         = r_done;
  assign Stall        = Req && !r_done;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - directed self-checking bench for lsu_ctrl
module tb_lsu_ctrl;
  localparam int ADDR_W = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Req;
  logic        MemWrite;
  logic [1:0]  DataWidth;
  logic        Unsigned;
  logic [31:0] Addr;
  logic [31:0] WData;
  logic [31:0] RData;
  logic        Done;
  logic        Stall;
  logic        MisalignErr;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  lsu_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  lsu_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Req        (Req),
    .MemWrite   (MemWrite),
    .DataWidth  (DataWidth),
    .Unsigned   (Unsigned),
    .Addr       (Addr),
    .WData      (WData),
    .RData      (RData),
    .Done       (Done),
    .Stall      (Stall),
    .MisalignErr(MisalignErr),
    .bus        (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic issue(input logic we, input logic [1:0] w, input logic u,
                       input logic [31:0] a, input logic [31:0] d);
    Req       = 1'b1;
    MemWrite  = we;
    DataWidth = w;
    Unsigned  = u;
    Addr      = a;
    WData     = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int err_cnt;
    logic seen;

    rst_n = 1'b0; Req = 1'b0; MemWrite = 1'b0; DataWidth = 2'b00; Unsigned = 1'b0;
    Addr = 32'h0; WData = 32'h0; bus.BusReady = 1'b0; bus.BusRData = 32'h0;
    repeat (2) @(negedge clk);

    check("rst_valid", bus.BusValid, 0);
    check("rst_we", bus.BusWe, 0);
    check("rst_done", Done, 0);
    check("rst_merr", MisalignErr, 0);
    check("rst_addr", bus.BusAddr, 0);
    check("rst_be", bus.BusBe, 0);
    check("rst_wdata", bus.BusWData, 0);
    check("rst_rdata", RData, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Aligned word load
    bus.BusReady = 1'b1; bus.BusRData = 32'hDEADBEEF;
    issue(1'b0, 2'b00, 1'b0, 32'h100, 32'h0);
    @(negedge clk);
    check("lw_valid", bus.BusValid, 1);
    check("lw_addr", bus.BusAddr, 32'h100);
    check("lw_be", bus.BusBe, 4'b1111);
    check("lw_we", bus.BusWe, 0);
    check("lw_stall", Stall, 1);
    check("lw_done_c1", Done, 0);
    @(negedge clk);
    check("lw_done", Done, 1);
    check("lw_rdata", RData, 32'hDEADBEEF);
    check("lw_valid_off", bus.BusValid, 0);
    check("lw_stall_off", Stall, 0);
    Req = 1'b0;
    @(negedge clk);
    check("lw_done_pulse", Done, 0);

    // Signed byte load at offset 3
    bus.BusRData = 32'h80123456;
    issue(1'b0, 2'b10, 1'b0, 32'h103, 32'h0);
    @(negedge clk);
    check("lb_be", bus.BusBe, 4'b1000);
    check("lb_addr", bus.BusAddr, 32'h100);
    @(negedge clk);
    check("lb_done", Done, 1);
    check("lb_rdata", RData, 32'hFFFFFF80);
    Req = 1'b0;
    @(negedge clk);

    // Unsigned byte load at offset 3
    issue(1'b0, 2'b10, 1'b1, 32'h103, 32'h0);
    repeat (2) @(negedge clk);
    check("lbu_done", Done, 1);
    check("lbu_rdata", RData, 32'h00000080);
    Req = 1'b0;
    @(negedge clk);

    // Half store at offset 2 with BusReady low for 3 cycles
    bus.BusReady = 1'b0;
    issue(1'b1, 2'b01, 1'b0, 32'h202, 32'h1234ABCD);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("sh_valid", bus.BusValid, 1);
      check("sh_addr", bus.BusAddr, 32'h200);
      check("sh_be", bus.BusBe, 4'b1100);
      check("sh_wdata", bus.BusWData, 32'hABCD0000);
      check("sh_we", bus.BusWe, 1);
      check("sh_nodone", Done, 0);
      if (k == 4) bus.BusReady = 1'b1;
    end
    @(negedge clk);
    check("sh_done", Done, 1);
    check("sh_rdata", RData, 32'h0);
    check("sh_valid_off", bus.BusValid, 0);
    Req = 1'b0;
    @(negedge clk);
    check("sh_done_pulse", Done, 0);

    // Misaligned word load at 0x301
    bus.BusReady = 1'b1;
`ifdef LSU_MISALIGN_EN
    bus.BusRData = 32'h332211AA;
    issue(1'b0, 2'b00, 1'b0, 32'h301, 32'h0);
    @(negedge clk);
    check("mis_b0_valid", bus.BusValid, 1);
    check("mis_b0_addr", bus.BusAddr, 32'h300);
    check("mis_b0_be", bus.BusBe, 4'b1110);
    bus.BusRData = 32'h99887744;
    @(negedge clk);
    check("mis_b1_valid", bus.BusValid, 1);
    check("mis_b1_addr", bus.BusAddr, 32'h304);
    check("mis_b1_be", bus.BusBe, 4'b0001);
    check("mis_b1_nodone", Done, 0);
    @(negedge clk);
    check("mis_done", Done, 1);
    check("mis_rdata", RData, 32'h44332211);
    check("mis_merr", MisalignErr, 0);
    Req = 1'b0;
    @(negedge clk);
`else
    issue(1'b0, 2'b00, 1'b0, 32'h301, 32'h0);
    err_cnt = 0;
    seen    = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (MisalignErr) err_cnt++;
      seen = seen | bus.BusValid;
      if (k == 1) check("mis_merr_c1", MisalignErr, 1);
      check("mis_stall", Stall, 1);
    end
    check("mis_merr_once", err_cnt, 1);
    check("mis_no_valid", seen, 0);
    Req = 1'b0;
    @(negedge clk);
`endif

    // Half access at 0xFFFFFFFF: second beat wraps to address 0
`ifdef LSU_MISALIGN_EN
    bus.BusRData = 32'hAB000000;
    issue(1'b0, 2'b01, 1'b0, 32'hFFFFFFFF, 32'h0);
    @(negedge clk);
    check("wrap_b0_addr", bus.BusAddr, 32'hFFFFFFFC);
    check("wrap_b0_be", bus.BusBe, 4'b1000);
    bus.BusRData = 32'h000000CD;
    @(negedge clk);
    check("wrap_b1_addr", bus.BusAddr, 32'h00000000);
    check("wrap_b1_be", bus.BusBe, 4'b0001);
    @(negedge clk);
    check("wrap_rdata", RData, 32'hFFFFCDAB);
    Req = 1'b0;
    @(negedge clk);
`else
    issue(1'b0, 2'b01, 1'b0, 32'hFFFFFFFF, 32'h0);
    @(negedge clk);
    check("wrap_merr", MisalignErr, 1);
    check("wrap_no_valid", bus.BusValid, 0);
    Req = 1'b0;
    @(negedge clk);
    check("wrap_merr_off", MisalignErr, 0);
`endif

    // Asynchronous reset in the middle of a stalled transaction
    bus.BusReady = 1'b0;
`ifdef LSU_MISALIGN_EN
    issue(1'b0, 2'b00, 1'b0, 32'h301, 32'h0);
    @(negedge clk);
    bus.BusReady = 1'b1;
    @(negedge clk);
    check("rstmid_b1_addr", bus.BusAddr, 32'h304);
    bus.BusReady = 1'b0;
`else
    issue(1'b0, 2'b00, 1'b0, 32'h100, 32'h0);
    @(negedge clk);
`endif
    check("rstmid_valid_pre", bus.BusValid, 1);
    #2 rst_n = 1'b0;
    #1 check("rstmid_valid_async", bus.BusValid, 0);
    Req  = 1'b0;
    seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      seen = seen | Done;
    end
    rst_n = 1'b1;
    @(negedge clk);
    seen = seen | Done;
    check("rstmid_no_done", seen, 0);

    // Fresh access after reset release
    bus.BusReady = 1'b1; bus.BusRData = 32'h0BADF00D;
    issue(1'b0, 2'b00, 1'b0, 32'h100, 32'h0);
    @(negedge clk);
    check("post_valid", bus.BusValid, 1);
    check("post_addr", bus.BusAddr, 32'h100);
    @(negedge clk);
    check("post_done", Done, 1);
    check("post_rdata", RData, 32'h0BADF00D);
    Req = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
